// File: rtl/brick_pkg.sv
// Shared geometry, state encoding and colour-table constants for the brick scanner.
package brick_pkg;

    localparam int DEF_COLS  = 10;
    localparam int DEF_ROWS  = 4;
    localparam int DEF_X0    = 0;
    localparam int DEF_Y0    = 10;
    localparam int BRICK_W   = 16;
    localparam int BRICK_H   = 4;
    localparam int ROW_PITCH = BRICK_H + 1;

    localparam logic [1:0] COLL_NONE = 2'b00;
    localparam logic [1:0] COLL_V    = 2'b01;
    localparam logic [1:0] COLL_H    = 2'b10;
    localparam logic [1:0] COLL_HV   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_ERASE,
        S_DONE
    } state_e;

    // Top rows are the toughest bricks; everything below row 2 starts at colour 1.
    function automatic logic [2:0] row_colour(input int row);
        case (row)
            0:       return 3'd4;
            1:       return 3'd3;
            2:       return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [7:0] brick_x(input int x0, input int col);
        return 8'(x0 + col * BRICK_W);
    endfunction

    function automatic logic [6:0] brick_y(input int y0, input int row);
        return 7'(y0 + row * ROW_PITCH);
    endfunction

endpackage

// File: rtl/brick_store.sv
// Brick colour register file: one combinational read port, one write port, whole-table reload.
module brick_store
    import brick_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
)(
    input  logic       clock,
    input  logic       resetn,
    input  logic       restore_i,
    input  logic [5:0] rd_idx_i,
    output logic [2:0] rd_colour_o,
    input  logic       wr_en_i,
    input  logic [5:0] wr_idx_i,
    input  logic [2:0] wr_colour_i
);

    localparam int N = COLS * ROWS;

    logic [2:0] colour_q [N];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) colour_q[i] <= row_colour(i / COLS);
        end else if (restore_i) begin
            for (int i = 0; i < N; i++) colour_q[i] <= row_colour(i / COLS);
        end else if (wr_en_i) begin
            colour_q[wr_idx_i] <= wr_colour_i;
        end
    end

    assign rd_colour_o = colour_q[rd_idx_i];

endmodule

// File: rtl/brick_scanner.sv
// Walks every brick past the collision detector, clears the first hit and hands the redraw to the VGA writer.
// Define BRICK_DURABLE_EN to make hit bricks lose one colour step instead of vanishing.
module brick_scanner
    import brick_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int X0   = DEF_X0,
    parameter int Y0   = DEF_Y0
)(
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        restore,
    input  logic [1:0]  brick_collision,
    output logic [18:0] brick_out,
    output logic        enable_brick_detector,
    output logic        busy,
    output logic        scan_done,
    output logic        hit,
    output logic [1:0]  hit_dir,
    output logic        erase_valid,
    input  logic        erase_ready,
    output logic [7:0]  erase_x,
    output logic [6:0]  erase_y,
    output logic [2:0]  erase_colour,
    output logic [5:0]  bricks_left
);

    localparam int N  = COLS * ROWS;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_e        state_q, state_d;
    logic [5:0]    idx_q, prev_idx_q, hit_idx_q;
    logic [CW-1:0] col_q, prev_col_q, hit_col_q;
    logic [RW-1:0] row_q, prev_row_q, hit_row_q;
    logic          found_q;
    logic [1:0]    hit_code_q;
    logic [5:0]    left_q;

    logic       accept_start, sample_window, capture, transfer;
    logic [5:0] rd_idx;
    logic [2:0] cur_colour, new_colour;

    // The detector reply lags one cycle, so the brick it refers to is the one held in prev_*.
    assign accept_start  = (state_q == S_IDLE) && start && !restore;
    assign sample_window = ((state_q == S_SCAN) && (idx_q != '0)) || (state_q == S_DRAIN);
    assign capture       = sample_window && !found_q && (brick_collision != COLL_NONE);
    assign transfer      = (state_q == S_ERASE) && erase_ready;
    assign rd_idx        = (state_q == S_ERASE) ? hit_idx_q : idx_q;

`ifdef BRICK_DURABLE_EN
    assign new_colour = (cur_colour > 3'd1) ? (cur_colour - 3'd1) : 3'd0;
`else
    assign new_colour = 3'd0;
`endif

    brick_store #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_store (
        .clock       (clock),
        .resetn      (resetn),
        .restore_i   (restore && (state_q == S_IDLE)),
        .rd_idx_i    (rd_idx),
        .rd_colour_o (cur_colour),
        .wr_en_i     (transfer),
        .wr_idx_i    (hit_idx_q),
        .wr_colour_i (new_colour)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept_start) state_d = S_SCAN;
            S_SCAN:  if (idx_q == 6'(N - 1)) state_d = S_DRAIN;
            S_DRAIN: state_d = (found_q || capture) ? S_ERASE : S_DONE;
            S_ERASE: if (erase_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            prev_idx_q <= '0;
            prev_col_q <= '0;
            prev_row_q <= '0;
            hit_idx_q  <= '0;
            hit_col_q  <= '0;
            hit_row_q  <= '0;
            found_q    <= 1'b0;
            hit_code_q <= COLL_NONE;
        end else begin
            if (accept_start) begin
                idx_q      <= '0;
                col_q      <= '0;
                row_q      <= '0;
                found_q    <= 1'b0;
                hit_code_q <= COLL_NONE;
            end else if (state_q == S_SCAN) begin
                prev_idx_q <= idx_q;
                prev_col_q <= col_q;
                prev_row_q <= row_q;
                idx_q      <= idx_q + 6'd1;
                if (int'(col_q) == COLS - 1) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            if (capture) begin
                found_q    <= 1'b1;
                hit_code_q <= brick_collision;
                hit_idx_q  <= prev_idx_q;
                hit_col_q  <= prev_col_q;
                hit_row_q  <= prev_row_q;
            end
        end
    end

    // Only a brick that actually drops to background leaves the count; durable steps do not.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            left_q <= 6'(N);
        end else if ((state_q == S_IDLE) && restore) begin
            left_q <= 6'(N);
        end else if (transfer && (cur_colour != 3'd0) && (new_colour == 3'd0) && (left_q != '0)) begin
            left_q <= left_q - 6'd1;
        end
    end

    assign busy                  = (state_q != S_IDLE);
    assign enable_brick_detector = (state_q == S_SCAN);
    assign brick_out             = enable_brick_detector
                                 ? {brick_x(X0, int'(col_q)), 1'b0, brick_y(Y0, int'(row_q)), cur_colour}
                                 : '0;
    assign scan_done             = (state_q == S_DONE);
    assign hit                   = found_q;
    assign hit_dir               = hit_code_q;
    assign erase_valid           = (state_q == S_ERASE);
    assign erase_x               = erase_valid ? brick_x(X0, int'(hit_col_q)) : '0;
    assign erase_y               = erase_valid ? brick_y(Y0, int'(hit_row_q)) : '0;
    assign erase_colour          = erase_valid ? new_colour : '0;
    assign bricks_left           = left_q;

endmodule

// File: tb/tb_brick_scanner.sv
// Self-checking bench for brick_scanner: behavioural colour-table model plus directed literal checks.
// Honours BRICK_DURABLE_EN the same way as the design.
module tb_brick_scanner;

    localparam int N = 40;

    logic        clock = 1'b0;
    logic        resetn, start, restore, erase_ready;
    logic [1:0]  brick_collision;
    logic [18:0] brick_out;
    logic        enable_brick_detector, busy, scan_done, hit, erase_valid;
    logic [1:0]  hit_dir;
    logic [7:0]  erase_x;
    logic [6:0]  erase_y;
    logic [2:0]  erase_colour;
    logic [5:0]  bricks_left;

    int errCount   = 0;
    int checkCount = 0;
    int cyc        = 0;

    logic [2:0] colM [N];
    logic [1:0] respM [N];
    int         leftM;

    logic        chkOn = 1'b0, chkHit = 1'b0;
    logic        expBusy, expEn, expDone, expEv, expHit;
    logic [18:0] expBo;
    logic [7:0]  expEx;
    logic [6:0]  expEy;
    logic [2:0]  expEc;
    logic [5:0]  expLeft;
    logic [1:0]  expDir;

    int         obsDoneCyc;
    logic       obsHit;
    logic [1:0] obsDir;
    logic [7:0] obsEx;
    logic [6:0] obsEy;
    logic [2:0] obsEc;

    brick_scanner dut (
        .clock                 (clock),
        .resetn                (resetn),
        .start                 (start),
        .restore               (restore),
        .brick_collision       (brick_collision),
        .brick_out             (brick_out),
        .enable_brick_detector (enable_brick_detector),
        .busy                  (busy),
        .scan_done             (scan_done),
        .hit                   (hit),
        .hit_dir               (hit_dir),
        .erase_valid           (erase_valid),
        .erase_ready           (erase_ready),
        .erase_x               (erase_x),
        .erase_y               (erase_y),
        .erase_colour          (erase_colour),
        .bricks_left           (bricks_left)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] modelX(input int i);
        return 8'((i % 10) * 16);
    endfunction

    function automatic logic [6:0] modelY(input int i);
        return 7'(10 + (i / 10) * 5);
    endfunction

    task automatic initModel();
        for (int i = 0; i < N; i++) colM[i] = 3'(4 - i / 10);
        leftM = N;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act != exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic setIdleExp();
        expBusy = 1'b0;
        expEn   = 1'b0;
        expDone = 1'b0;
        expEv   = 1'b0;
        expLeft = 6'(leftM);
    endtask

    task automatic clearObs();
        obsDoneCyc = -1;
        obsHit     = 1'bx;
        obsDir     = 2'b11;
        obsEx      = 8'hff;
        obsEy      = 7'h7f;
        obsEc      = 3'h7;
    endtask

    // Single compare process: DUT outputs against the per-cycle model expectations.
    always @(negedge clock) begin
        if (chkOn) begin
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("enable", 32'(enable_brick_detector), 32'(expEn));
            checkOutput("scan_done", 32'(scan_done), 32'(expDone));
            checkOutput("erase_valid", 32'(erase_valid), 32'(expEv));
            checkOutput("bricks_left", 32'(bricks_left), 32'(expLeft));
            if (expEn) checkOutput("brick_out", 32'(brick_out), 32'(expBo));
            if (expEv) begin
                checkOutput("erase_x", 32'(erase_x), 32'(expEx));
                checkOutput("erase_y", 32'(erase_y), 32'(expEy));
                checkOutput("erase_colour", 32'(erase_colour), 32'(expEc));
            end
            if (chkHit) begin
                checkOutput("hit", 32'(hit), 32'(expHit));
                checkOutput("hit_dir", 32'(hit_dir), 32'(expDir));
            end
        end
        if (erase_valid) begin
            obsEx = erase_x;
            obsEy = erase_y;
            obsEc = erase_colour;
        end
        if (scan_done) begin
            obsDoneCyc = cyc;
            obsHit     = hit;
            obsDir     = hit_dir;
        end
    end

    // One full scan: cycle 0 carries start, bricks in cycles 1..N, drain N+1, erase, done, idle.
    task automatic applyStimulus(input int stall, input bit abortErase);
        int         hitIdx;
        logic [2:0] oldC, newC;
        hitIdx = -1;
        for (int i = 0; i < N; i++) if (hitIdx < 0 && respM[i] != 2'b00) hitIdx = i;
        clearObs();
        cyc = 0;
        start = 1'b1; restore = 1'b0; brick_collision = 2'b00; erase_ready = 1'b0;
        setIdleExp();
        nextCycle();
        chkHit = 1'b0;
        for (int c = 1; c <= N; c++) begin
            start           = ($urandom_range(0, 5) == 0);
            restore         = ($urandom_range(0, 7) == 0);
            brick_collision = (c >= 2) ? respM[c-2] : 2'b00;
            expBusy = 1'b1;
            expEn   = 1'b1;
            expBo   = {modelX(c-1), 1'b0, modelY(c-1), colM[c-1]};
            nextCycle();
        end
        start = 1'b0; restore = 1'b0;
        brick_collision = respM[N-1];
        expEn = 1'b0;
        nextCycle();
        brick_collision = 2'b00;
        if (hitIdx >= 0) begin
            oldC = colM[hitIdx];
`ifdef BRICK_DURABLE_EN
            newC = (oldC > 3'd1) ? oldC - 3'd1 : 3'd0;
`else
            newC = 3'd0;
`endif
            for (int s = 0; s <= stall; s++) begin
                erase_ready = (s == stall);
                expEv = 1'b1;
                expEx = modelX(hitIdx);
                expEy = modelY(hitIdx);
                expEc = newC;
                if (abortErase && s == 1) begin
                    @(negedge clock);
                    #2;
                    chkOn  = 1'b0;
                    resetn = 1'b0;
                    #1;
                    checkOutput("rst_erase_valid", 32'(erase_valid), 32'd0);
                    checkOutput("rst_bricks_left", 32'(bricks_left), 32'd40);
                    checkOutput("rst_busy", 32'(busy), 32'd0);
                    checkOutput("rst_hit", 32'(hit), 32'd0);
                    initModel();
                    erase_ready = 1'b0;
                    @(posedge clock);
                    #1;
                    resetn = 1'b1;
                    setIdleExp();
                    expHit = 1'b0;
                    expDir = 2'b00;
                    chkHit = 1'b1;
                    chkOn  = 1'b1;
                    return;
                end
                nextCycle();
            end
            erase_ready = 1'b0;
            expEv = 1'b0;
            colM[hitIdx] = newC;
            if (oldC != 3'd0 && newC == 3'd0 && leftM > 0) leftM--;
        end
        expDone = 1'b1;
        expLeft = 6'(leftM);
        expHit  = (hitIdx >= 0);
        expDir  = (hitIdx >= 0) ? respM[hitIdx] : 2'b00;
        chkHit  = 1'b1;
        nextCycle();
        expDone = 1'b0;
        expBusy = 1'b0;
        nextCycle();
    endtask

    task automatic doRestore(input bit withStart);
        restore = 1'b1;
        start   = withStart;
        setIdleExp();
        nextCycle();
        restore = 1'b0;
        start   = 1'b0;
        initModel();
        setIdleExp();
        nextCycle();
    endtask

    task automatic clearResp();
        for (int i = 0; i < N; i++) respM[i] = 2'b00;
    endtask

    initial begin
        int guard;
        resetn = 1'b0; start = 1'b0; restore = 1'b0;
        brick_collision = 2'b00; erase_ready = 1'b0;
        initModel();
        setIdleExp();
        expHit = 1'b0; expDir = 2'b00; chkHit = 1'b1;
        chkOn  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;

        $display("[TB] scan with no replies");
        clearResp();
        applyStimulus(0, 1'b0);
        checkOutput("lit_done_cycle_nohit", 32'(obsDoneCyc), 32'd42);
        checkOutput("lit_hit_nohit", 32'(obsHit), 32'd0);
        checkOutput("lit_left_nohit", 32'(bricks_left), 32'd40);

        $display("[TB] single reply on brick 3");
        clearResp();
        respM[3] = 2'b01;
        applyStimulus(0, 1'b0);
        checkOutput("lit_erase_x_b3", 32'(obsEx), 32'd48);
        checkOutput("lit_erase_y_b3", 32'(obsEy), 32'd10);
        checkOutput("lit_hit_dir_b3", 32'(obsDir), 32'd1);
        checkOutput("lit_done_cycle_hit", 32'(obsDoneCyc), 32'd43);
`ifdef BRICK_DURABLE_EN
        checkOutput("lit_erase_colour_b3", 32'(obsEc), 32'd3);
        checkOutput("lit_left_b3", 32'(bricks_left), 32'd40);
`else
        checkOutput("lit_erase_colour_b3", 32'(obsEc), 32'd0);
        checkOutput("lit_left_b3", 32'(bricks_left), 32'd39);
`endif

        $display("[TB] two replies, first wins");
        clearResp();
        respM[5] = 2'b10;
        respM[7] = 2'b11;
        applyStimulus(0, 1'b0);
        checkOutput("lit_hit_dir_first", 32'(obsDir), 32'd2);
        checkOutput("lit_erase_x_first", 32'(obsEx), 32'd80);

        $display("[TB] erase stalled five cycles");
        clearResp();
        respM[12] = 2'b01;
        applyStimulus(5, 1'b0);
        checkOutput("lit_done_cycle_stall", 32'(obsDoneCyc), 32'd48);
        checkOutput("lit_erase_x_b12", 32'(obsEx), 32'd32);
        checkOutput("lit_erase_y_b12", 32'(obsEy), 32'd15);

        $display("[TB] reset during erase");
        clearResp();
        respM[0] = 2'b11;
        applyStimulus(4, 1'b1);

        $display("[TB] repeated hit on brick 0");
        clearResp();
        respM[0] = 2'b01;
        applyStimulus(0, 1'b0);
`ifdef BRICK_DURABLE_EN
        checkOutput("lit_durable_first", 32'(obsEc), 32'd3);
        applyStimulus(1, 1'b0);
        checkOutput("lit_durable_second", 32'(obsEc), 32'd2);
        checkOutput("lit_durable_left", 32'(bricks_left), 32'd40);
`else
        checkOutput("lit_clear_b0", 32'(obsEc), 32'd0);
        checkOutput("lit_clear_b0_left", 32'(bricks_left), 32'd39);
`endif

        $display("[TB] restore with start in idle");
        doRestore(1'b1);
        checkOutput("lit_restore_left", 32'(bricks_left), 32'd40);

        $display("[TB] randomized scans");
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < N; i++)
                respM[i] = (colM[i] != 3'd0 && $urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            applyStimulus($urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 4) == 0) doRestore(1'($urandom_range(0, 1)));
        end

        $display("[TB] clearing every brick");
        guard = 0;
        while (leftM != 0 && guard < 200) begin
            clearResp();
            for (int i = N - 1; i >= 0; i--) if (colM[i] != 3'd0) respM[i] = 2'($urandom_range(1, 3));
            applyStimulus($urandom_range(0, 2), 1'b0);
            guard++;
        end
        checkOutput("lit_left_zero", 32'(bricks_left), 32'd0);
        clearResp();
        applyStimulus(0, 1'b0);
        checkOutput("lit_empty_hit", 32'(obsHit), 32'd0);
        checkOutput("lit_empty_done_cycle", 32'(obsDoneCyc), 32'd42);
        checkOutput("lit_empty_left", 32'(bricks_left), 32'd0);

        doRestore(1'b0);
        checkOutput("lit_final_restore_left", 32'(bricks_left), 32'd40);

        chkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
